// File: rtl/block_slider.sv
// Moving-block driver for one stacker row: slides the block left/right on a tick,
// and on a stop press clips it against the block below to produce the row result.
module block_slider #(
  parameter int SCREEN_W = 320,
  parameter int CELL_W   = 16,
  parameter int TICK_DIV = 2_500_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_level,
  input  logic       first_row,
  input  logic       stop_btn,
  input  logic [8:0] prev_block_start,
  input  logic [8:0] prev_block_end,
  input  logic [3:0] prev_block_size,
  output logic [8:0] curr_block_start,
  output logic [8:0] curr_block_end,
  output logic [3:0] curr_block_size,
  output logic       stop_true,
  output logic       intersect_true,
  output logic       moving
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [9:0] CELL_W10     = 10'(CELL_W);
  localparam logic [9:0] SCREEN_MAX10 = 10'(SCREEN_W - 1);
  localparam logic [8:0] CELL_W9      = 9'(CELL_W);

  typedef enum logic [2:0] {IDLE, LOAD, MOVE, CHECK, REPORT} state_t;

  state_t          state_q, state_d;
  logic [8:0]      start_q, start_d;
  logic [8:0]      end_q, end_d;
  logic [3:0]      size_q, size_d;
  logic            dir_left_q, dir_left_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            first_q, first_d;
  logic            inter_q, inter_d;
  logic            stop_q;

  logic [9:0] start10, end10, pstart10, pend10, lo10, hi10;
  logic       can_right, can_left, tick_last, stop_edge;
  logic [8:0] nxt_start;

  function automatic logic [8:0] end_of(input logic [8:0] s, input logic [3:0] sz);
    return 9'({1'b0, s} + 10'(sz) * CELL_W10 - 10'd1);
  endfunction

  assign start10   = {1'b0, start_q};
  assign end10     = {1'b0, end_q};
  assign pstart10  = {1'b0, prev_block_start};
  assign pend10    = {1'b0, prev_block_end};
  assign can_right = (end10 + CELL_W10) <= SCREEN_MAX10;
  assign can_left  = start10 >= CELL_W10;
  assign tick_last = (tick_q == TW'(TICK_DIV - 1));
  assign stop_edge = stop_btn & ~stop_q;

  // On the first row the base is the whole screen, so the block is its own overlap.
  assign lo10 = first_q ? start10 : ((start10 > pstart10) ? start10 : pstart10);
  assign hi10 = first_q ? end10   : ((end10 < pend10) ? end10 : pend10);

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    end_d      = end_q;
    size_d     = size_q;
    dir_left_d = dir_left_q;
    tick_d     = tick_q;
    first_d    = first_q;
    inter_d    = inter_q;
    nxt_start  = start_q;
    case (state_q)
      IDLE: begin
        if (start_level && (prev_block_size != 4'd0)) state_d = LOAD;
      end
      LOAD: begin
        size_d     = prev_block_size;
        start_d    = 9'd0;
        end_d      = end_of(9'd0, prev_block_size);
        dir_left_d = 1'b0;
        tick_d     = '0;
        first_d    = first_row;
        inter_d    = 1'b0;
        state_d    = MOVE;
      end
      MOVE: begin
        if (stop_edge) begin
          state_d = CHECK;
        end else begin
          tick_d = tick_last ? '0 : tick_q + TW'(1);
          if (tick_last) begin
            // Bounce: reverse at a wall and take the step in the new direction if it fits.
            if (!dir_left_q) begin
              if (can_right) nxt_start = start_q + CELL_W9;
              else begin
                dir_left_d = 1'b1;
                if (can_left) nxt_start = start_q - CELL_W9;
              end
            end else begin
              if (can_left) nxt_start = start_q - CELL_W9;
              else begin
                dir_left_d = 1'b0;
                if (can_right) nxt_start = start_q + CELL_W9;
              end
            end
            start_d = nxt_start;
            end_d   = end_of(nxt_start, size_q);
          end
        end
      end
      CHECK: begin
        if (lo10 <= hi10) begin
          start_d = 9'(lo10);
          end_d   = 9'(hi10);
          size_d  = 4'((hi10 - lo10 + 10'd1) / CELL_W10);
          inter_d = 1'b1;
        end else begin
          start_d = 9'd0;
          end_d   = 9'd0;
          size_d  = 4'd0;
          inter_d = 1'b0;
        end
        state_d = REPORT;
      end
      REPORT: begin
        inter_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      start_q    <= 9'd0;
      end_q      <= 9'd0;
      size_q     <= 4'd0;
      dir_left_q <= 1'b0;
      tick_q     <= '0;
      first_q    <= 1'b0;
      inter_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      end_q      <= end_d;
      size_q     <= size_d;
      dir_left_q <= dir_left_d;
      tick_q     <= tick_d;
      first_q    <= first_d;
      inter_q    <= inter_d;
      stop_q     <= stop_btn;
    end
  end

  assign curr_block_start = start_q;
  assign curr_block_end   = end_q;
  assign curr_block_size  = size_q;
  assign intersect_true   = inter_q;
  assign stop_true        = (state_q == REPORT);
  assign moving           = (state_q == MOVE);

endmodule

// File: tb/tb_block_slider.sv
// Randomized scoreboard bench for block_slider with a bounce-path reference model.
module tb_block_slider;

  localparam int SW = 320;
  localparam int CW = 16;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start_level = 1'b0;
  logic       first_row = 1'b0;
  logic       stop_btn = 1'b0;
  logic [8:0] prev_block_start = '0;
  logic [8:0] prev_block_end = '0;
  logic [3:0] prev_block_size = '0;
  logic [8:0] curr_block_start, curr_block_end;
  logic [3:0] curr_block_size;
  logic       stop_true, intersect_true, moving;

  block_slider #(.SCREEN_W(SW), .CELL_W(CW), .TICK_DIV(TD)) dut (
    .clk(clk), .resetn(resetn), .start_level(start_level), .first_row(first_row),
    .stop_btn(stop_btn), .prev_block_start(prev_block_start),
    .prev_block_end(prev_block_end), .prev_block_size(prev_block_size),
    .curr_block_start(curr_block_start), .curr_block_end(curr_block_end),
    .curr_block_size(curr_block_size), .stop_true(stop_true),
    .intersect_true(intersect_true), .moving(moving)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int s; int e; int z; int i; int c;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Block position after k steps: a triangle wave between 0 and the rightmost legal start.
  function automatic int tri_pos(input int k, input int sz);
    int m, p;
    m = (SW - sz * CW) / CW;
    if (m <= 0) return 0;
    p = k % (2 * m);
    return ((p <= m) ? p : 2 * m - p) * CW;
  endfunction

  function automatic exp_t model(input bit fr, input int sz, input int ps, input int pe, input int k);
    exp_t x;
    int s, e, lo, hi;
    s = tri_pos(k, sz);
    e = s + sz * CW - 1;
    lo = fr ? s : ((s > ps) ? s : ps);
    hi = fr ? e : ((e < pe) ? e : pe);
    if (lo <= hi) begin
      x.s = lo; x.e = hi; x.z = (hi - lo + 1) / CW; x.i = 1;
    end else begin
      x.s = 0; x.e = 0; x.z = 0; x.i = 0;
    end
    x.c = 0;
    return x;
  endfunction

  // Monitor: every stop_true cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (stop_true) begin
      if (q.size() == 0) begin
        chk("unexpected_stop_true", 1, 0);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("stop_latency", cyc, x.c);
        chk("res_start", int'(curr_block_start), x.s);
        chk("res_end", int'(curr_block_end), x.e);
        chk("res_size", int'(curr_block_size), x.z);
        chk("res_intersect", int'(intersect_true), x.i);
      end
    end
  end

  // d = number of MOVE-state clock edges before the edge that samples the stop press.
  task automatic trial(input bit fr, input int sz, input int ps, input int pe, input int d);
    int n, e, k;
    exp_t x;
    @(negedge clk);
    first_row = fr;
    prev_block_size = 4'(sz);
    prev_block_start = 9'(ps);
    prev_block_end = 9'(pe);
    start_level = 1'b1;
    n = cyc + 1;
    e = n + 2 + d;
    @(negedge clk);
    start_level = 1'b0;
    chk("moving_in_load", int'(moving), 0);
    while (cyc < e - 1) begin
      @(negedge clk);
      k = (cyc - n - 1) / TD;
      chk("moving", int'(moving), 1);
      chk("track_start", int'(curr_block_start), tri_pos(k, sz));
      chk("track_end", int'(curr_block_end), tri_pos(k, sz) + sz * CW - 1);
    end
    stop_btn = 1'b1;
    x = model(fr, sz, ps, pe, d / TD);
    x.c = e + 1;
    q.push_back(x);
    @(negedge clk);
    stop_btn = 1'b0;
    while (cyc < e + 2) @(negedge clk);
    chk("report_seen", q.size(), 0);
    q.delete();
    chk("idle_intersect", int'(intersect_true), 0);
    chk("idle_moving", int'(moving), 0);
    chk("hold_start", int'(curr_block_start), x.s);
    chk("hold_size", int'(curr_block_size), x.z);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sz, ps, d;
    bit fr;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", int'(curr_block_start), 0);
    chk("rst_end", int'(curr_block_end), 0);
    chk("rst_size", int'(curr_block_size), 0);
    chk("rst_stop_true", int'(stop_true), 0);
    chk("rst_intersect", int'(intersect_true), 0);
    chk("rst_moving", int'(moving), 0);
    resetn = 1'b1;

    // Zero-size start is ignored
    @(negedge clk);
    prev_block_size = 4'd0;
    start_level = 1'b1;
    @(negedge clk);
    start_level = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("zero_size_idle", int'(moving), 0);
    end

    trial(1'b1, 5, 0, 0, 8);          // first row, stop after 2 steps
    trial(1'b0, 5, 64, 143, 25);      // partial overlap at start 96
    trial(1'b0, 2, 0, 31, 17);        // miss at start 64
    trial(1'b1, 5, 0, 0, 31 * TD + 3); // full bounce, stop on a tick edge
    trial(1'b0, 15, 0, 239, 11 * TD + 3);

    for (int t = 0; t < 10; t++) begin
      sz = $urandom_range(1, 15);
      ps = CW * $urandom_range(0, (SW - sz * CW) / CW);
      fr = ($urandom_range(0, 4) == 0);
      d = $urandom_range(0, 70);
      trial(fr, sz, ps, ps + sz * CW - 1, d);
    end

    // Reset in the middle of MOVE
    @(negedge clk);
    first_row = 1'b1;
    prev_block_size = 4'd3;
    start_level = 1'b1;
    @(negedge clk);
    start_level = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_moving", int'(moving), 1);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_start", int'(curr_block_start), 0);
    chk("midrst_end", int'(curr_block_end), 0);
    chk("midrst_size", int'(curr_block_size), 0);
    chk("midrst_moving", int'(moving), 0);
    chk("midrst_stop_true", int'(stop_true), 0);
    resetn = 1'b1;
    @(negedge clk);
    stop_btn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stop_after_reset", int'(stop_true), 0);
      chk("idle_after_reset", int'(moving), 0);
    end
    stop_btn = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
